// File: rtl/comp_acc.sv
// Complex accumulator: sums a stream of complex products, one vector per i_last,
// into a single saturated complex result with valid/ready output flow control.
module comp_acc #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_FRAC_BIT = 30,
  parameter int unsigned GUARD_BITS   = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    i_last,
  input  logic [2*DATA_WIDTH-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_res,
  output logic [CNT_WIDTH-1:0]    o_cnt,
  output logic                    o_sat
);

  localparam int unsigned AccWidth = DATA_WIDTH + GUARD_BITS;

  // The fixed-point format passes straight through; only its sanity matters here.
  if (NUM_FRAC_BIT >= DATA_WIDTH) begin : g_frac_check
    $error("comp_acc: NUM_FRAC_BIT must be smaller than DATA_WIDTH");
  end

  typedef enum logic [0:0] {StAcc, StFull} state_e;

  state_e state_q, state_d;

  logic [AccWidth-1:0]     acc_re_q, acc_im_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [2*DATA_WIDTH-1:0] res_q;
  logic [CNT_WIDTH-1:0]    res_cnt_q;
  logic                    sat_q;

  logic                    accept;
  logic [AccWidth-1:0]     term_re, term_im;
  logic [AccWidth-1:0]     sum_re, sum_im;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    ovf_re, ovf_im;
  logic [DATA_WIDTH-1:0]   sat_re, sat_im;

  // True when the value does not fit in DATA_WIDTH signed bits.
  function automatic logic overflows(input logic [AccWidth-1:0] v);
    return (|v[AccWidth-1:DATA_WIDTH-1]) && !(&v[AccWidth-1:DATA_WIDTH-1]);
  endfunction

  // Clamp to the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] clamp(input logic [AccWidth-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (!overflows(v)) begin
      r = v[DATA_WIDTH-1:0];
    end else if (v[AccWidth-1]) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completed vector fills the result register; a handshake drains it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc: begin
        if (accept && i_last) state_d = StFull;
      end
      StFull: begin
        if (i_ready) state_d = (accept && i_last) ? StFull : StAcc;
      end
      default: state_d = StAcc;
    endcase
  end

  // Flow-control outputs; no accumulation while a result is stalled.
  always_comb begin
    o_valid = (state_q == StFull);
    o_ready = !o_valid || i_ready;
  end

  // Sign-extended term, running sums, saturated results and saturating count.
  always_comb begin
    accept  = i_valid && o_ready;
    term_re = {{GUARD_BITS{i_data[2*DATA_WIDTH-1]}}, i_data[2*DATA_WIDTH-1:DATA_WIDTH]};
    term_im = {{GUARD_BITS{i_data[DATA_WIDTH-1]}}, i_data[DATA_WIDTH-1:0]};
    sum_re  = acc_re_q + term_re;
    sum_im  = acc_im_q + term_im;
    ovf_re  = overflows(sum_re);
    ovf_im  = overflows(sum_im);
    sat_re  = clamp(sum_re);
    sat_im  = clamp(sum_im);
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  // Accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_cnt_q <= '0;
      sat_q     <= 1'b0;
    end else if (accept) begin
      if (i_last) begin
        res_q     <= {sat_re, sat_im};
        res_cnt_q <= cnt_inc;
        sat_q     <= ovf_re || ovf_im;
        acc_re_q  <= '0;
        acc_im_q  <= '0;
        cnt_q     <= '0;
      end else begin
        acc_re_q  <= sum_re;
        acc_im_q  <= sum_im;
        cnt_q     <= cnt_inc;
      end
    end
  end

  assign o_res = res_q;
  assign o_cnt = res_cnt_q;
  assign o_sat = sat_q;

endmodule

// File: tb/tb_comp_acc.sv
// Scoreboard bench for comp_acc: stimulus pushes expected results, a monitor
// pops and compares on every output handshake.
module tb_comp_acc;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [2*DW-1:0] res;
    logic [CW-1:0]   cnt;
    logic            sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_last, i_ready;
  logic [2*DW-1:0] i_data;
  logic          o_ready, o_valid, o_sat;
  logic [2*DW-1:0] o_res;
  logic [CW-1:0] o_cnt;

  int   errors = 0;
  int   checks = 0;
  int   hs_count = 0;
  int   cyc = 0;
  int   hs_cyc[$];
  exp_t exp_q[$];

  comp_acc #(
    .DATA_WIDTH  (DW),
    .NUM_FRAC_BIT(30),
    .GUARD_BITS  (8),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_res  (o_res),
    .o_cnt  (o_cnt),
    .o_sat  (o_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] res, input logic [CW-1:0] cnt, input logic sat);
    exp_t e;
    e.res = res;
    e.cnt = cnt;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  // Offer one term and return just after the edge that accepted it.
  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
    int n = 0;
    i_valid = 1'b1;
    i_last  = last;
    i_data  = {re, im};
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_ready stayed %b, expected 1", o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_o_ready"}, 64'(o_ready), 64'd1);
    chk({tag, "_o_res"},   o_res,        64'd0);
    chk({tag, "_o_cnt"},   64'(o_cnt),   64'd0);
    chk({tag, "_o_sat"},   64'(o_sat),   64'd0);
  endtask

  // Monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      exp_t e;
      hs_count++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res=%h cnt=%0d, expected none", o_res, o_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("res", o_res, e.res);
        chk("cnt", 64'(o_cnt), 64'(e.cnt));
        chk("sat", 64'(o_sat), 64'(e.sat));
      end
    end
  end

  initial begin
    int hs0;
    int n0;
    int n;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;

    // Basic sum: 4 x (0.25 + 0.25j).
    push({32'h4000_0000, 32'h4000_0000}, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(32'h1000_0000, 32'h1000_0000, i == 3);
    @(negedge clk);
    chk("latency_o_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1;
    idle(2);

    // Signed cancel.
    push(64'd0, 16'd2, 1'b0);
    send(32'h4000_0000, 32'hC000_0000, 1'b0);
    send(32'hC000_0000, 32'h4000_0000, 1'b1);
    idle(3);

    // Saturation on both components.
    push({32'h7FFF_FFFF, 32'h8000_0000}, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h6000_0000, 32'hA000_0000, i == 3);
    idle(3);

    // Backpressure: hold the result, refuse terms, then exactly one handshake.
    i_ready = 1'b0;
    push({32'h0000_0030, 32'h0000_0000}, 16'd2, 1'b0);
    send(32'h0000_0010, 32'hFFFF_FFF0, 1'b0);
    send(32'h0000_0020, 32'h0000_0010, 1'b1);
    hs0 = hs_count;
    i_valid = 1'b1;
    i_last  = 1'b0;
    i_data  = {32'h0000_0001, 32'h0000_0001};
    repeat (5) begin
      @(negedge clk);
      chk("stall_o_ready", 64'(o_ready), 64'd0);
      chk("stall_o_res", o_res, {32'h0000_0030, 32'h0000_0000});
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    idle(3);
    chk("stall_handshakes", 64'(hs_count - hs0), 64'd1);
    push({32'h0000_0007, 32'h0000_0006}, 16'd2, 1'b0);
    send(32'h0000_0003, 32'h0000_0007, 1'b0);
    send(32'h0000_0004, 32'hFFFF_FFFF, 1'b1);
    idle(3);

    // Back-to-back single-term vectors.
    hs0 = hs_count;
    n0  = hs_cyc.size();
    for (int i = 1; i <= 3; i++) begin
      push({32'(i), 32'h0}, 16'd1, 1'b0);
      send(32'(i), 32'h0, 1'b1);
    end
    idle(3);
    chk("b2b_handshakes", 64'(hs_count - hs0), 64'd3);
    if (hs_cyc.size() >= n0 + 3) begin
      chk("b2b_consecutive", 64'(hs_cyc[n0+2] - hs_cyc[n0]), 64'd2);
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_consecutive: got %0d handshakes, expected 3", hs_cyc.size() - n0);
    end

    // Reset mid-vector.
    send(32'h0000_0100, 32'h0000_0100, 1'b0);
    send(32'h0000_0100, 32'h0000_0100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    @(posedge clk); #1;
    push({32'h0000_0005, 32'h0000_0000}, 16'd1, 1'b0);
    send(32'h0000_0005, 32'h0000_0000, 1'b1);
    idle(3);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pending_results", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_acc.md
Name: comp_acc

Overview:
- Complex accumulator stage directly downstream of the complex multiplier.
- Consumes a stream of complex products ({re, im}, fixed-point) and sums each vector of terms, delimited by i_last, into one complex result. This computes one row of a gate-matrix × state-vector product.
- Extends precision internally with guard bits, saturates on output, and provides valid/ready flow control toward the downstream consumer.

Parameters:
- DATA_WIDTH, 32, width of each real/imag component.
- NUM_FRAC_BIT, 30, fractional bits; the format passes through unchanged.
- GUARD_BITS, 8, extra accumulator MSBs per component.
- CNT_WIDTH, 16, width of the term counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  product term valid; already aligned to multiplier latency upstream.
- i_last  input  1  final term of the current vector; qualified by i_valid.
- i_data  input  2*DATA_WIDTH  term {re, im}, two's complement.
- o_ready  output  1  upstream may present a term this cycle.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_res  output  2*DATA_WIDTH  saturated sum {re, im}.
- o_cnt  output  CNT_WIDTH  number of terms in o_res.
- o_sat  output  1  re or im saturated; qualified by o_valid.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Term acceptance: a term is accepted when i_valid && o_ready.
- Accumulators: acc_re and acc_im are each DATA_WIDTH+GUARD_BITS wide. Terms are sign-extended, then added with wrap inside the accumulator.
- States:
  - ACC: empty or partial sum.
  - FULL: result register occupied, o_valid=1.
- ACC, accepted term with i_last=0: acc += term; cnt += 1.
- ACC, accepted term with i_last=1:
  - result = sat(acc + term) per component; o_cnt = cnt + 1.
  - acc is cleared and cnt is cleared.
  - Go to FULL next cycle.
  - Latency is 1 cycle from the last term to o_valid.
- Saturation: sat() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. o_sat = 1 if either component clamped.
- FULL, result handshake: when o_valid && i_ready, the result is consumed. Go to ACC unless a new last term completes in the same cycle.
- o_ready = !o_valid || i_ready.
  - Terms, including non-last ones, are accepted only when o_ready=1.
  - Simplified rule: no accumulation while a result is stalled.
- Simultaneous events: result consumed and a new last term accepted in the same cycle. The new result loads and o_valid stays 1 (back-to-back vectors at 1 result per cycle, including single-term vectors).
- Stability: o_res, o_cnt and o_sat hold stable while o_valid && !i_ready.
- Counter overflow: cnt saturates at 2^CNT_WIDTH-1. Summation continues.
- Single-term vector (i_valid && i_last, acc empty): o_res = sat(term), o_cnt = 1.
- Idle inputs: i_last without i_valid is ignored. i_valid=0 leaves all state unchanged.
- Reset, including mid-vector or with a pending result:
  - acc=0, cnt=0, state=ACC.
  - o_valid=0, o_res=0, o_cnt=0, o_sat=0.
  - o_ready=1 in the cycle after rst deasserts.
- No arithmetic rounding; all values share the Q(DATA_WIDTH-NUM_FRAC_BIT).NUM_FRAC_BIT format.

Test Plan:
- Basic sum: 4 terms {0x1000_0000, 0x1000_0000} (0.25+0.25j), last on the 4th, i_ready=1 → one cycle later o_valid=1, o_res={0x4000_0000, 0x4000_0000}, o_cnt=4, o_sat=0.
- Signed cancel: terms {0x4000_0000, 0xC000_0000} and {0xC000_0000, 0x4000_0000}, last on the 2nd → o_res={0,0}, o_cnt=2.
- Saturation: 4 terms {0x6000_0000, 0xA000_0000} (±1.5 each) → o_res={0x7FFF_FFFF, 0x8000_0000}, o_sat=1.
- Backpressure: i_ready=0 for 5 cycles after o_valid → o_ready=0, o_res held constant, offered terms not absorbed. Releasing i_ready gives exactly one handshake, and the next vector then sums correctly.
- Back-to-back single-term vectors: i_valid=i_last=1 for 3 cycles with values 1, 2, 3 (LSB units) and i_ready=1 → o_valid high for 3 consecutive cycles, o_res.re = 1, 2, 3, o_cnt=1 each.
- Reset mid-vector: 2 non-last terms, assert rst 1 cycle, then 1 last term {0x0000_0005, 0} → o_res={5, 0}, o_cnt=1. All outputs are 0 during and right after reset.
